tlb_unit: RTL and testbench
===========================

Name: tlb_unit

Overview:
- 16-entry, fully associative, MIPS32-style joint TLB.
- Sits on the other side of the CP0 TLB interface. Consumes CP0 EntryHi/EntryLo0/EntryLo1/Index/Random values and executes TLBWI/TLBWR/TLBR/TLBP.
- Returns probe results, readback data and TLB exceptions to CP0.
- Translates instruction/data virtual addresses with a one-cycle registered result.

Parameters:
- ENTRIES, 16, number of TLB entries (index width = 4; no other value is supported).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- cpu_pause_i  in  1  pipeline stall; freezes every register when high
- instr_tlbwi_i  in  1  TLBWI pulse
- instr_tlbwr_i  in  1  TLBWR pulse
- instr_tlbr_i  in  1  TLBR pulse
- instr_tlbp_i  in  1  TLBP pulse
- cp0_index_i  in  32  CP0 Index; bits [3:0] used
- cp0_random_i  in  32  CP0 Random; bits [3:0] used
- cp0_entryhi_i  in  32  VPN2 = [31:13], ASID = [7:0]
- cp0_entrylo0_i  in  32  PFN = [25:6], C = [5:3], D = [2], V = [1], G = [0]
- cp0_entrylo1_i  in  32  same layout as cp0_entrylo0_i
- trans_req_i  in  1  translation request
- trans_vaddr_i  in  32  virtual address
- trans_rw_i  in  1  1 = store, 0 = load/fetch
- trans_by_instr_i  in  1  request is an instruction fetch
- trans_paddr_o  out  32  physical address
- trans_valid_o  out  1  result valid
- tlb_entryhi_match_index_o  out  4  TLBP matching index
- tlb_entryhi_hit_o  out  1  TLBP hit
- cp0_entryhi_o  out  32  TLBR EntryHi readback
- cp0_entryhi_data_valid_o  out  1  TLBR EntryHi valid
- cp0_entrylo0_o  out  32  TLBR EntryLo0 readback
- cp0_entrylo0_data_valid_o  out  1  TLBR EntryLo0 valid
- cp0_entrylo1_o  out  32  TLBR EntryLo1 readback
- cp0_entrylo1_data_valid_o  out  1  TLBR EntryLo1 valid
- cp0_bad_vaddr_o  out  32  faulting virtual address
- exception_tlb_refill_o  out  1  refill exception
- exception_tlb_invalid_o  out  1  invalid exception
- exception_tlb_mod_o  out  1  modify exception
- exception_tlb_rw_o  out  1  rw flag of the faulting access
- exception_tlb_by_instr_o  out  1  fault was an instruction fetch

Behaviour:
- Single clock clk; reset is synchronous and active-high.
- Entry fields: VPN2[18:0], ASID[7:0], G, PFN0/C0/D0/V0, PFN1/C1/D1/V1.
- Reset:
  - all entries: V0 = V1 = G = 0, VPN2 = 0.
  - all outputs 0, except trans_paddr_o = 0 and cp0_bad_vaddr_o = 0.
- cpu_pause_i = 1: nothing is written; all registered outputs hold.
- Op priority when several op pulses are high in one cycle: tlbwi > tlbwr > tlbr > tlbp. Only the winning op executes.
- TLBWI: writes entry cp0_index_i[3:0] at the clock edge.
  - G = entrylo0.G AND entrylo1.G.
  - ASID taken from EntryHi[7:0].
- TLBWR: same as TLBWI, but the target is cp0_random_i[3:0].
- TLBR:
  - Next cycle: entry cp0_index_i[3:0] appears on cp0_entryhi_o, cp0_entrylo0_o and cp0_entrylo1_o.
    - cp0_entryhi_o = {VPN2, 5'b0, ASID}.
    - Lo = {6'b0, PFN, C, D, V, G}.
  - The three *_data_valid_o outputs pulse high for exactly one unpaused cycle.
- TLBP:
  - Next cycle: tlb_entryhi_hit_o / tlb_entryhi_match_index_o are updated and held until the next TLBP.
  - Match rule: VPN2 equal AND (G OR ASID equal).
  - Multiple matches: the lowest index wins.
  - Miss: hit = 0, index holds its previous value.
- Translation (latency 1):
  - trans_req_i sampled at edge N; result registered at N+1; trans_valid_o pulses for one cycle.
  - vaddr[31:30] == 2'b10 (kseg0/kseg1): unmapped. paddr = {3'b0, vaddr[28:0]}, no exception.
  - All other addresses are mapped, using ASID = cp0_entryhi_i[7:0].
  - Page select: vaddr[12]. 0 → even page (PFN0/V0/D0), 1 → odd page (PFN1/V1/D1).
  - On hit with V = 1 and (rw = 0 or D = 1): paddr = {PFN[19:0], vaddr[11:0]}.
- Exceptions (mutually exclusive, one-cycle pulses coincident with trans_valid_o):
  - No match → refill.
  - Match with V = 0 → invalid.
  - Match, V = 1, D = 0, rw = 1 → mod.
  - On any exception: cp0_bad_vaddr_o = vaddr; exception_tlb_rw_o = rw; exception_tlb_by_instr_o = by_instr; trans_paddr_o = 0.
- Write and translate in the same cycle: the translation uses the pre-write contents. A translation in the following cycle sees the new entry.
- Reset asserted mid-operation: any pending TLBR/TLBP/translation result is discarded; outputs return to reset values.

Test Plan:
- Reset, then translate vaddr 0x0040_0000 load → exception_tlb_refill_o = 1, cp0_bad_vaddr_o = 0x0040_0000, trans_valid_o = 1, exactly one cycle later.
- TLBWI index 3: EntryHi = 0x0040_0005, Lo0 = 0x0000_1046 (PFN = 0x41, D = 1, V = 1), Lo1 = 0. Translate 0x0040_0123 with ASID 5 → paddr = 0x0004_1123, no exception. Translate 0x0040_1000 → invalid.
- Same entry with Lo0.D = 0; store to 0x0040_0010 → exception_tlb_mod_o = 1, exception_tlb_rw_o = 1. A load to the same address succeeds.
- TLBP with EntryHi = 0x0040_0005 → hit = 1, index = 3. Change ASID to 6 (G = 0) → hit = 0, index stays 3.
- TLBR with Index = 3 → next cycle: cp0_entryhi_o = 0x0040_0005, cp0_entrylo0_o = 0x0000_1046, all three data_valid_o high for one cycle.
- Translate 0x8000_1234 → paddr = 0x0000_1234. Pause high for 3 cycles during a TLBWI → entry unchanged until pause drops.

Source files
------------

// File: rtl/tlb_unit.sv
// tlb_unit: 16-entry fully associative MIPS32-style joint TLB with CP0 ops and one-cycle registered translation.
module tlb_unit #(
   parameter int ENTRIES = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_pause_i,
   input  logic        instr_tlbwi_i,
   input  logic        instr_tlbwr_i,
   input  logic        instr_tlbr_i,
   input  logic        instr_tlbp_i,
   input  logic [31:0] cp0_index_i,
   input  logic [31:0] cp0_random_i,
   input  logic [31:0] cp0_entryhi_i,
   input  logic [31:0] cp0_entrylo0_i,
   input  logic [31:0] cp0_entrylo1_i,
   input  logic        trans_req_i,
   input  logic [31:0] trans_vaddr_i,
   input  logic        trans_rw_i,
   input  logic        trans_by_instr_i,
   output logic [31:0] trans_paddr_o,
   output logic        trans_valid_o,
   output logic [3:0]  tlb_entryhi_match_index_o,
   output logic        tlb_entryhi_hit_o,
   output logic [31:0] cp0_entryhi_o,
   output logic        cp0_entryhi_data_valid_o,
   output logic [31:0] cp0_entrylo0_o,
   output logic        cp0_entrylo0_data_valid_o,
   output logic [31:0] cp0_entrylo1_o,
   output logic        cp0_entrylo1_data_valid_o,
   output logic [31:0] cp0_bad_vaddr_o,
   output logic        exception_tlb_refill_o,
   output logic        exception_tlb_invalid_o,
   output logic        exception_tlb_mod_o,
   output logic        exception_tlb_rw_o,
   output logic        exception_tlb_by_instr_o
);
   typedef struct packed {
      logic [18:0] vpn2;
      logic [7:0]  asid;
      logic        g;
      logic [19:0] pfn0;
      logic [2:0]  c0;
      logic        d0;
      logic        v0;
      logic [19:0] pfn1;
      logic [2:0]  c1;
      logic        d1;
      logic        v1;
   } entry_t;

   entry_t      ent_q [ENTRIES];
   entry_t      ent_d, r_ent;
   logic        wr_en, op_r, op_p;
   logic [3:0]  wr_idx;
   logic        p_hit, t_hit;
   logic [3:0]  p_idx, t_idx;
   logic        unmapped, odd, pg_v, pg_d, refill, invalid, modify, exc;
   logic [19:0] pg_pfn;
   logic [31:0] paddr_d;

   logic [31:0] paddr_q, bad_vaddr_q, rhi_q, rlo0_q, rlo1_q;
   logic [3:0]  pidx_q;
   logic        valid_q, refill_q, invalid_q, mod_q, rw_q, by_instr_q, phit_q, rvalid_q;

   logic unused;
   assign unused = ^{cp0_index_i[31:4], cp0_random_i[31:4], cp0_entryhi_i[12:8],
                     cp0_entrylo0_i[31:26], cp0_entrylo1_i[31:26]};

   always_comb begin
      wr_en  = instr_tlbwi_i | instr_tlbwr_i;
      wr_idx = instr_tlbwi_i ? cp0_index_i[3:0] : cp0_random_i[3:0];
      op_r   = instr_tlbr_i & ~wr_en;
      op_p   = instr_tlbp_i & ~wr_en & ~instr_tlbr_i;
      ent_d  = {cp0_entryhi_i[31:13], cp0_entryhi_i[7:0], cp0_entrylo0_i[0] & cp0_entrylo1_i[0],
                cp0_entrylo0_i[25:1], cp0_entrylo1_i[25:1]};
      p_hit  = 1'b0;
      p_idx  = 4'd0;
      t_hit  = 1'b0;
      t_idx  = 4'd0;
      // Scan downward so the lowest matching index is the one left standing.
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (ent_q[i].vpn2 == cp0_entryhi_i[31:13] && (ent_q[i].g || ent_q[i].asid == cp0_entryhi_i[7:0])) begin
            p_hit = 1'b1;
            p_idx = 4'(i);
         end
         if (ent_q[i].vpn2 == trans_vaddr_i[31:13] && (ent_q[i].g || ent_q[i].asid == cp0_entryhi_i[7:0])) begin
            t_hit = 1'b1;
            t_idx = 4'(i);
         end
      end
      r_ent    = ent_q[cp0_index_i[3:0]];
      unmapped = trans_vaddr_i[31:30] == 2'b10;
      odd      = trans_vaddr_i[12];
      pg_pfn   = odd ? ent_q[t_idx].pfn1 : ent_q[t_idx].pfn0;
      pg_v     = odd ? ent_q[t_idx].v1 : ent_q[t_idx].v0;
      pg_d     = odd ? ent_q[t_idx].d1 : ent_q[t_idx].d0;
      refill   = ~unmapped & ~t_hit;
      invalid  = ~unmapped & t_hit & ~pg_v;
      modify   = ~unmapped & t_hit & pg_v & ~pg_d & trans_rw_i;
      exc      = refill | invalid | modify;
      paddr_d  = unmapped ? {3'b0, trans_vaddr_i[28:0]} : exc ? 32'd0 : {pg_pfn, trans_vaddr_i[11:0]};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) ent_q[i] <= '0;
         paddr_q     <= '0;
         bad_vaddr_q <= '0;
         rhi_q       <= '0;
         rlo0_q      <= '0;
         rlo1_q      <= '0;
         pidx_q      <= '0;
         valid_q     <= 1'b0;
         refill_q    <= 1'b0;
         invalid_q   <= 1'b0;
         mod_q       <= 1'b0;
         rw_q        <= 1'b0;
         by_instr_q  <= 1'b0;
         phit_q      <= 1'b0;
         rvalid_q    <= 1'b0;
      end else if (!cpu_pause_i) begin
         if (wr_en) ent_q[wr_idx] <= ent_d;
         valid_q   <= trans_req_i;
         refill_q  <= trans_req_i & refill;
         invalid_q <= trans_req_i & invalid;
         mod_q     <= trans_req_i & modify;
         if (trans_req_i) paddr_q <= paddr_d;
         if (trans_req_i && exc) begin
            bad_vaddr_q <= trans_vaddr_i;
            rw_q        <= trans_rw_i;
            by_instr_q  <= trans_by_instr_i;
         end
         rvalid_q <= op_r;
         if (op_r) begin
            rhi_q  <= {r_ent.vpn2, 5'b0, r_ent.asid};
            rlo0_q <= {6'b0, r_ent.pfn0, r_ent.c0, r_ent.d0, r_ent.v0, r_ent.g};
            rlo1_q <= {6'b0, r_ent.pfn1, r_ent.c1, r_ent.d1, r_ent.v1, r_ent.g};
         end
         if (op_p) begin
            phit_q <= p_hit;
            if (p_hit) pidx_q <= p_idx;
         end
      end
   end

   assign trans_paddr_o             = paddr_q;
   assign trans_valid_o             = valid_q;
   assign tlb_entryhi_match_index_o = pidx_q;
   assign tlb_entryhi_hit_o         = phit_q;
   assign cp0_entryhi_o             = rhi_q;
   assign cp0_entrylo0_o            = rlo0_q;
   assign cp0_entrylo1_o            = rlo1_q;
   assign cp0_entryhi_data_valid_o  = rvalid_q;
   assign cp0_entrylo0_data_valid_o = rvalid_q;
   assign cp0_entrylo1_data_valid_o = rvalid_q;
   assign cp0_bad_vaddr_o           = bad_vaddr_q;
   assign exception_tlb_refill_o    = refill_q;
   assign exception_tlb_invalid_o   = invalid_q;
   assign exception_tlb_mod_o       = mod_q;
   assign exception_tlb_rw_o        = rw_q;
   assign exception_tlb_by_instr_o  = by_instr_q;
endmodule

// File: tb/tb_tlb_unit.sv
// tb_tlb_unit: directed bench for tlb_unit with hand-computed expectations.
module tb_tlb_unit;
   logic        clk = 1'b0;
   logic        reset, pause, wi, wr, rd, pr, req, rw, byi;
   logic [31:0] idx, rnd, hi, lo0, lo1, va;
   logic [31:0] paddr, ehi, elo0, elo1, badva;
   logic [3:0]  midx;
   logic        tvalid, hit, hiv, lo0v, lo1v, refill, inval, modx, erw, ebyi;
   int          checks = 0;
   int          failures = 0;

   tlb_unit dut (
      .clk(clk), .reset(reset), .cpu_pause_i(pause),
      .instr_tlbwi_i(wi), .instr_tlbwr_i(wr), .instr_tlbr_i(rd), .instr_tlbp_i(pr),
      .cp0_index_i(idx), .cp0_random_i(rnd), .cp0_entryhi_i(hi),
      .cp0_entrylo0_i(lo0), .cp0_entrylo1_i(lo1),
      .trans_req_i(req), .trans_vaddr_i(va), .trans_rw_i(rw), .trans_by_instr_i(byi),
      .trans_paddr_o(paddr), .trans_valid_o(tvalid),
      .tlb_entryhi_match_index_o(midx), .tlb_entryhi_hit_o(hit),
      .cp0_entryhi_o(ehi), .cp0_entryhi_data_valid_o(hiv),
      .cp0_entrylo0_o(elo0), .cp0_entrylo0_data_valid_o(lo0v),
      .cp0_entrylo1_o(elo1), .cp0_entrylo1_data_valid_o(lo1v),
      .cp0_bad_vaddr_o(badva),
      .exception_tlb_refill_o(refill), .exception_tlb_invalid_o(inval),
      .exception_tlb_mod_o(modx), .exception_tlb_rw_o(erw),
      .exception_tlb_by_instr_o(ebyi)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      wi = 0; wr = 0; rd = 0; pr = 0; req = 0; rw = 0; byi = 0;
   endtask

   initial begin
      reset = 1; pause = 0; idle();
      idx = 0; rnd = 0; hi = 32'h0040_0005; lo0 = 0; lo1 = 0; va = 0;
      tick(); tick();
      chk("rst_valid", {31'd0, tvalid}, 0);
      chk("rst_paddr", paddr, 0);
      chk("rst_badva", badva, 0);
      chk("rst_hit", {31'd0, hit}, 0);
      chk("rst_rvalid", {31'd0, hiv}, 0);
      reset = 0;
      tick();
      // refill on empty TLB, result exactly one cycle later
      req = 1; va = 32'h0040_0000; byi = 1;
      tick();
      chk("refill_valid", {31'd0, tvalid}, 1);
      chk("refill_flag", {31'd0, refill}, 1);
      chk("refill_badva", badva, 32'h0040_0000);
      chk("refill_byi", {31'd0, ebyi}, 1);
      chk("refill_paddr", paddr, 0);
      idle();
      tick();
      chk("valid_pulse", {31'd0, tvalid}, 0);
      chk("refill_pulse", {31'd0, refill}, 0);
      // write entry 3 while translating: translation sees the old contents
      wi = 1; idx = 3; lo0 = 32'h0000_1046; lo1 = 0;
      req = 1; va = 32'h0040_0123;
      tick();
      chk("prewrite_refill", {31'd0, refill}, 1);
      idle(); req = 1;
      tick();
      chk("hit_paddr", paddr, 32'h0004_1123);
      chk("hit_valid", {31'd0, tvalid}, 1);
      chk("hit_noexc", {29'd0, refill, inval, modx}, 0);
      va = 32'h0040_1000;
      tick();
      chk("odd_invalid", {31'd0, inval}, 1);
      chk("odd_inv_badva", badva, 32'h0040_1000);
      chk("odd_inv_paddr", paddr, 0);
      // clean page: store faults, load succeeds
      idle(); wi = 1; lo0 = 32'h0000_1042;
      tick();
      idle(); req = 1; va = 32'h0040_0010; rw = 1;
      tick();
      chk("mod_flag", {31'd0, modx}, 1);
      chk("mod_rw", {31'd0, erw}, 1);
      chk("mod_byi", {31'd0, ebyi}, 0);
      chk("mod_badva", badva, 32'h0040_0010);
      rw = 0;
      tick();
      chk("load_ok_paddr", paddr, 32'h0004_1010);
      chk("load_ok_mod", {31'd0, modx}, 0);
      // probe hit then ASID miss
      idle(); pr = 1;
      tick();
      chk("tlbp_hit", {31'd0, hit}, 1);
      chk("tlbp_idx", {28'd0, midx}, 3);
      hi = 32'h0040_0006;
      tick();
      chk("tlbp_miss", {31'd0, hit}, 0);
      chk("tlbp_idx_hold", {28'd0, midx}, 3);
      // tlbwi beats tlbr in the same cycle
      idle(); hi = 32'h0040_0005; wi = 1; rd = 1; lo0 = 32'h0000_1046;
      tick();
      chk("prio_no_read", {31'd0, hiv}, 0);
      idle(); rd = 1;
      tick();
      chk("tlbr_hi", ehi, 32'h0040_0005);
      chk("tlbr_lo0", elo0, 32'h0000_1046);
      chk("tlbr_lo1", elo1, 0);
      chk("tlbr_valids", {29'd0, hiv, lo0v, lo1v}, 3'b111);
      idle();
      tick();
      chk("tlbr_valid_pulse", {29'd0, hiv, lo0v, lo1v}, 0);
      chk("tlbr_hold", elo0, 32'h0000_1046);
      // unmapped, then pause during a write
      req = 1; va = 32'h8000_1234;
      tick();
      chk("kseg_paddr", paddr, 32'h0000_1234);
      chk("kseg_noexc", {29'd0, refill, inval, modx}, 0);
      va = 32'h8000_0010;
      tick();
      idle(); pause = 1; wi = 1; idx = 5; hi = 32'h0060_0005; lo0 = 32'h0000_1046; lo1 = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("pause_hold_valid", {31'd0, tvalid}, 1);
         chk("pause_hold_paddr", paddr, 32'h0000_0010);
      end
      pause = 0; idle(); req = 1; va = 32'h0060_0000;
      tick();
      chk("pause_nowrite", {31'd0, refill}, 1);
      idle(); wi = 1;
      tick();
      idle(); req = 1;
      tick();
      chk("post_pause_paddr", paddr, 32'h0004_1000);
      // global entry at index 1 via tlbwr: lowest index wins
      idle(); wr = 1; rnd = 1; hi = 32'h0040_0006; lo0 = 32'h0000_2047; lo1 = 32'h0000_0001;
      tick();
      idle(); hi = 32'h0040_0005; pr = 1; req = 1; va = 32'h0040_0123;
      tick();
      chk("multi_hit", {31'd0, hit}, 1);
      chk("multi_idx", {28'd0, midx}, 1);
      chk("global_paddr", paddr, 32'h0008_1123);
      // reset discards a pending read and clears the entries
      idle(); rd = 1; idx = 3; reset = 1;
      tick();
      chk("rst_mid_rvalid", {31'd0, hiv}, 0);
      chk("rst_mid_ehi", ehi, 0);
      chk("rst_mid_hit", {31'd0, hit}, 0);
      reset = 0; idle(); req = 1; va = 32'h0040_0123;
      tick();
      chk("rst_cleared", {31'd0, refill}, 1);
      idle();
      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
